mult_feeder: RTL
================

MULT_FEEDER -- requirements
Module: mult_feeder

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8: operand width of weight and feature pixels.
REQ-002 SHALL have parameter KERNEL_LEN, default 9: number of products accumulated per output sum, legal range 1..255.
REQ-003 SHALL have parameter PROD_LAT, default 3: number of cycles from the issue pulse to a valid product at i_mul_product, legal range 1..7.
REQ-004 SHALL have parameter ACC_WIDTH, default 2*BIT_WIDTH+4: width of the accumulator and of o_sum.
REQ-005 SHALL use one clock and a synchronous, active-high reset; the clock port SHALL be i_clk and the reset port SHALL be i_rst.
REQ-006 Ports (name, direction, width, meaning):
  - i_clk, in, 1: clock.
  - i_rst, in, 1: synchronous active-high reset.
  - i_pair_valid, in, 1: upstream operand pair valid.
  - o_pair_ready, out, 1: feeder accepts the pair this cycle.
  - i_pix_weight, in, BIT_WIDTH: upstream weight.
  - i_pix_feature, in, BIT_WIDTH: upstream feature.
  - o_pix_weight, out, BIT_WIDTH: weight driven to the multiplier.
  - o_pix_feature, out, BIT_WIDTH: feature driven to the multiplier.
  - o_enable_colw, out, 1: issue strobe to the multiplier.
  - o_enable_colip, out, 1: issue strobe to the multiplier.
  - o_enable_core, out, 1: multiplier output enable.
  - i_mul_product, in, 2*BIT_WIDTH: unsigned product from the multiplier.
  - i_mul_start, in, 1: multiplier start acknowledge.
  - o_sum, out, ACC_WIDTH: completed dot-product.
  - o_sum_valid, out, 1: o_sum is valid.
  - i_sum_ready, in, 1: downstream accepts o_sum.
  - o_err, out, 1: sticky protocol error flag.

Function
REQ-007 SHALL implement a state machine with five states: IDLE, ISSUE, WAIT, ACC and DONE.
REQ-008 In IDLE: o_pair_ready=1. When i_pair_valid=1, the feeder SHALL register both operands and go to ISSUE.
REQ-009 ISSUE SHALL last exactly one cycle, with o_enable_colw=o_enable_colip=1 and o_pix_weight/o_pix_feature holding the registered operands.
REQ-010 ISSUE SHALL then go to WAIT.
REQ-011 o_enable_colw and o_enable_colip SHALL be high only in ISSUE, and both SHALL always be equal.
REQ-012 o_enable_core SHALL be 1 in WAIT and ACC, and 0 in all other states.
REQ-013 WAIT SHALL count PROD_LAT-1 cycles, then go to ACC.
REQ-014 ACC SHALL capture i_mul_product in the cycle that is exactly PROD_LAT cycles after the ISSUE cycle.
REQ-015 In ACC, the accumulator SHALL become acc + zero-extended product, and the pair counter SHALL increment.
REQ-016 After ACC, if the pair counter equals KERNEL_LEN the feeder SHALL go to DONE; otherwise it SHALL go to IDLE.
REQ-017 In DONE: o_sum_valid=1 and o_sum=acc.
REQ-018 In DONE, when i_sum_ready=1 the feeder SHALL clear acc and the pair counter and go to IDLE in the same cycle.
REQ-019 While o_sum_valid=1 and i_sum_ready=0, o_sum SHALL stay stable.
REQ-020 Throughput with no stall SHALL be one pair per PROD_LAT+2 cycles.
REQ-021 The first sum SHALL appear KERNEL_LEN*(PROD_LAT+2) cycles after the first accepted pair.
REQ-022 o_pair_ready SHALL be 0 in every state other than IDLE, and upstream pairs SHALL be held without loss.
REQ-023 If i_mul_start is not 1 in the cycle after ISSUE, o_err SHALL be set and SHALL stay set until reset; data flow SHALL continue unaffected.
REQ-024 With KERNEL_LEN=1, every ACC state SHALL go to DONE.

Reset
REQ-025 When i_rst=1 at a clock edge, the feeder SHALL enter IDLE.
REQ-026 Reset SHALL clear acc, the pair counter, the latency counter and the operand registers.
REQ-027 Reset values of the outputs SHALL be: o_pair_ready=1 in the first cycle after reset; o_pix_weight=0, o_pix_feature=0, o_enable_colw=0, o_enable_colip=0, o_enable_core=0, o_sum=0, o_sum_valid=0, o_err=0.
REQ-028 Reset asserted mid-operation (in any state) SHALL abandon the partial sum, and no o_sum_valid pulse SHALL follow.

Configuration
REQ-029 Macro MULT_FEEDER_ACC_SATURATE_EN, when defined, SHALL make the ACC addition saturate at 2^ACC_WIDTH-1.
REQ-030 With MULT_FEEDER_ACC_SATURATE_EN defined, the accumulator SHALL hold at the saturated value for the rest of the kernel.
REQ-031 Without MULT_FEEDER_ACC_SATURATE_EN, the ACC addition SHALL wrap modulo 2^ACC_WIDTH.

Structure
REQ-032 The state encoding typedef and the default values of BIT_WIDTH, PROD_LAT and KERNEL_LEN SHALL reside in the shared gan_common_define.vh constants.
REQ-033 The accumulator (add, with the optional saturation) SHALL be one sub-module named feeder_acc; everything else SHALL be inline.

Verification
REQ-034 Test 1: KERNEL_LEN=9, PROD_LAT=3, nine pairs (w=2, f=3) with a model multiplier -> o_sum=54 with o_sum_valid at cycle 45 after the first acceptance.
REQ-035 Test 2: pairs w=255, f=255 with KERNEL_LEN=9 -> o_sum=585225; with ACC_WIDTH=16 -> wrapped o_sum=0xEE09 without the macro, and 0xFFFF with MULT_FEEDER_ACC_SATURATE_EN.
REQ-036 Test 3: i_sum_ready held at 0 for 10 cycles in DONE -> o_sum stable, o_pair_ready=0 throughout, and the next kernel starts after the i_sum_ready pulse.
REQ-037 Test 4: i_rst=1 in WAIT of pair 5 -> all outputs at reset values next cycle; a following 9-pair run sums correctly from zero.
REQ-038 Test 5: model multiplier withholds i_mul_start once -> o_err=1 and stays 1, and o_sum is still correct.
REQ-039 Test 6: i_pair_valid toggled randomly -> every accepted pair is issued exactly once, and o_enable_colw == o_enable_colip in every cycle.

Source files
------------

// File: rtl/mult_feeder_pkg.sv
// Shared constants and types for the multiplier feeder: state encoding,
// default geometry and counter widths.
package mult_feeder_pkg;

   // Default operand width, kernel length and multiplier latency
   localparam int DEF_BIT_WIDTH  = 8;
   localparam int DEF_KERNEL_LEN = 9;
   localparam int DEF_PROD_LAT   = 3;

   // Counter widths sized for the largest legal kernel length (255)
   // and multiplier latency (7)
   localparam int PAIR_CNT_W = 8;
   localparam int LAT_CNT_W  = 3;

   // Feeder sequencing states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ACC   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/mult_feeder_if.sv
// Feeder <-> multiplier bus: operands and strobes toward the multiplier,
// product and start acknowledge back from it.
interface mult_feeder_if #(
   parameter int BIT_WIDTH = 8
);
   logic [BIT_WIDTH-1:0]   pix_weight;
   logic [BIT_WIDTH-1:0]   pix_feature;
   logic                   enable_colw;
   logic                   enable_colip;
   logic                   enable_core;
   logic [2*BIT_WIDTH-1:0] mul_product;
   logic                   mul_start;

   // Feeder side
   modport master (
      output pix_weight, pix_feature, enable_colw, enable_colip, enable_core,
      input  mul_product, mul_start
   );

   // Multiplier side
   modport slave (
      input  pix_weight, pix_feature, enable_colw, enable_colip, enable_core,
      output mul_product, mul_start
   );

   // Accumulator only needs to see the product
   modport acc_side (
      input mul_product
   );
endinterface

// File: rtl/feeder_acc.sv
// Dot-product accumulator for the feeder. Adds the zero-extended
// multiplier product when add_en is high; clear empties it after a sum
// has been handed off.
// Build option: MULT_FEEDER_ACC_SATURATE_EN -- when defined the addition
// clamps at the all-ones value instead of wrapping.
module feeder_acc #(
   parameter int ACC_WIDTH = 20
)(
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 clear,
   input  logic                 add_en,
   mult_feeder_if.acc_side      mul,
   output logic [ACC_WIDTH-1:0] acc
);

   logic [ACC_WIDTH-1:0] acc_reg;
   logic [ACC_WIDTH-1:0] acc_next;

`ifdef MULT_FEEDER_ACC_SATURATE_EN
   logic [ACC_WIDTH:0] sum_wide;

   // One extra bit catches the carry; on overflow clamp to all ones, which
   // also keeps a saturated accumulator pinned for the rest of the kernel
   always_comb begin
      sum_wide = {1'b0, acc_reg} + (ACC_WIDTH+1)'(mul.mul_product);
      acc_next = sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
   end
`else
   // Plain modular addition
   always_comb begin
      acc_next = acc_reg + ACC_WIDTH'(mul.mul_product);
   end
`endif

   // Accumulator register: reset and post-handoff clear take priority
   always_ff @(posedge clk) begin
      if (srst || clear) begin
         acc_reg <= '0;
      end else if (add_en) begin
         acc_reg <= acc_next;
      end
   end

   assign acc = acc_reg;

endmodule

// File: rtl/mult_feeder.sv
// Multiplier feeder: accepts weight/feature pairs one at a time, issues
// each to an external multiplier, waits its fixed latency, accumulates
// the product and after KERNEL_LEN pairs presents the dot-product with a
// valid/ready handshake. A missing start acknowledge sets a sticky error.
// Build option: MULT_FEEDER_ACC_SATURATE_EN (saturating accumulator,
// handled inside feeder_acc).
module mult_feeder
   import mult_feeder_pkg::*;
#(
   parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
   parameter int KERNEL_LEN = DEF_KERNEL_LEN,
   parameter int PROD_LAT   = DEF_PROD_LAT,
   parameter int ACC_WIDTH  = 2*BIT_WIDTH+4
)(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_pair_valid,
   output logic                   o_pair_ready,
   input  logic [BIT_WIDTH-1:0]   i_pix_weight,
   input  logic [BIT_WIDTH-1:0]   i_pix_feature,
   output logic [BIT_WIDTH-1:0]   o_pix_weight,
   output logic [BIT_WIDTH-1:0]   o_pix_feature,
   output logic                   o_enable_colw,
   output logic                   o_enable_colip,
   output logic                   o_enable_core,
   input  logic [2*BIT_WIDTH-1:0] i_mul_product,
   input  logic                   i_mul_start,
   output logic [ACC_WIDTH-1:0]   o_sum,
   output logic                   o_sum_valid,
   input  logic                   i_sum_ready,
   output logic                   o_err
);

   // Last pair index of a kernel and last WAIT count value; WAIT spends
   // PROD_LAT-1 cycles so that ACC lands PROD_LAT cycles after ISSUE
   localparam logic [PAIR_CNT_W-1:0] KERNEL_LAST = PAIR_CNT_W'(KERNEL_LEN - 1);
   localparam logic [LAT_CNT_W-1:0]  WAIT_LAST   = LAT_CNT_W'(PROD_LAT - 2);

   state_t                 state_reg;
   state_t                 state_next;
   logic [BIT_WIDTH-1:0]   weight_reg;
   logic [BIT_WIDTH-1:0]   feature_reg;
   logic [PAIR_CNT_W-1:0]  pair_cnt_reg;
   logic [LAT_CNT_W-1:0]   lat_cnt_reg;
   logic                   issue_d_reg;
   logic                   err_reg;

   logic                   pair_ready;
   logic                   issue_en;
   logic                   core_en;
   logic                   sum_valid;
   logic                   acc_add;
   logic                   acc_clear;
   logic [ACC_WIDTH-1:0]   acc_value;

   mult_feeder_if #(.BIT_WIDTH(BIT_WIDTH)) mul_bus ();

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and per-state strobes
   always_comb begin
      state_next = state_reg;
      pair_ready = 1'b0;
      issue_en   = 1'b0;
      core_en    = 1'b0;
      sum_valid  = 1'b0;
      acc_add    = 1'b0;
      acc_clear  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            pair_ready = 1'b1;
            if (i_pair_valid) begin
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            issue_en = 1'b1;
            // A single-cycle multiplier has its product ready right after
            // ISSUE, so there is nothing to wait for
            if (PROD_LAT > 1) begin
               state_next = ST_WAIT;
            end else begin
               state_next = ST_ACC;
            end
         end
         ST_WAIT: begin
            core_en = 1'b1;
            if (lat_cnt_reg == WAIT_LAST) begin
               state_next = ST_ACC;
            end
         end
         ST_ACC: begin
            core_en = 1'b1;
            acc_add = 1'b1;
            // The counter increments on this same edge, so compare against
            // the pre-increment value of the final pair
            if (pair_cnt_reg == KERNEL_LAST) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_DONE: begin
            sum_valid = 1'b1;
            if (i_sum_ready) begin
               acc_clear  = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Operand capture, pair counter and latency counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         weight_reg   <= '0;
         feature_reg  <= '0;
         pair_cnt_reg <= '0;
         lat_cnt_reg  <= '0;
      end else begin
         if (state_reg == ST_IDLE && i_pair_valid) begin
            weight_reg  <= i_pix_weight;
            feature_reg <= i_pix_feature;
         end
         if (state_reg == ST_WAIT) begin
            lat_cnt_reg <= lat_cnt_reg + 1'b1;
         end else begin
            lat_cnt_reg <= '0;
         end
         if (acc_add) begin
            pair_cnt_reg <= pair_cnt_reg + 1'b1;
         end else if (acc_clear) begin
            pair_cnt_reg <= '0;
         end
      end
   end

   // Sticky error: the multiplier must acknowledge in the cycle after ISSUE.
   // Only flags the fault; sequencing carries on regardless.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         issue_d_reg <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         issue_d_reg <= issue_en;
         if (issue_d_reg && !mul_bus.mul_start) begin
            err_reg <= 1'b1;
         end
      end
   end

   feeder_acc #(
      .ACC_WIDTH (ACC_WIDTH)
   ) u_feeder_acc (
      .clk    (i_clk),
      .srst   (i_rst),
      .clear  (acc_clear),
      .add_en (acc_add),
      .mul    (mul_bus),
      .acc    (acc_value)
   );

   // Multiplier-facing bus, routed through the interface bundle
   assign mul_bus.pix_weight   = weight_reg;
   assign mul_bus.pix_feature  = feature_reg;
   assign mul_bus.enable_colw  = issue_en;
   assign mul_bus.enable_colip = issue_en;
   assign mul_bus.enable_core  = core_en;
   assign mul_bus.mul_product  = i_mul_product;
   assign mul_bus.mul_start    = i_mul_start;

   assign o_pix_weight   = mul_bus.pix_weight;
   assign o_pix_feature  = mul_bus.pix_feature;
   assign o_enable_colw  = mul_bus.enable_colw;
   assign o_enable_colip = mul_bus.enable_colip;
   assign o_enable_core  = mul_bus.enable_core;

   assign o_pair_ready = pair_ready;
   assign o_sum_valid  = sum_valid;
   assign o_sum        = acc_value;
   assign o_err        = err_reg;

endmodule
